wb_port_arbiter: RTL and testbench

- Merges the pipeline's WB-stage write and results from the long-latency unit (multi-cycle mul/div) onto the single register file write port (wa/wd/we).
- Long-latency results are queued in a small FIFO and drain in cycles where the pipeline does not write.
- Reports pending queued writes per register to the hazard unit, so dependent instructions stall until their data lands.

---
 rtl/wb_port_arbiter_if.sv | 73 +++++++
 rtl/wb_port_arbiter.sv | 119 +++++++++++
 tb/tb_wb_port_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: WB write, long-latency result, hazard and RF port bundle.
// Optional WBARB_PERF_EN adds the perf_lu_wb / perf_defer counter outputs.
interface wb_port_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pipe_we;
    logic [AW-1:0] pipe_wa;
    logic [DW-1:0] pipe_wd;
    logic          lu_valid;
    logic [AW-1:0] lu_wa;
    logic [DW-1:0] lu_wd;
    logic          lu_ready;
    logic [AW-1:0] chk_ra1;
    logic [AW-1:0] chk_ra2;
    logic          pend1;
    logic          pend2;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [CW-1:0] fifo_cnt;
`ifdef WBARB_PERF_EN
    logic [31:0]   perf_lu_wb;
    logic [31:0]   perf_defer;
`endif

    modport master (
`ifdef WBARB_PERF_EN
        input  perf_lu_wb,
        input  perf_defer,
`endif
        output pipe_we,
        output pipe_wa,
        output pipe_wd,
        output lu_valid,
        output lu_wa,
        output lu_wd,
        input  lu_ready,
        output chk_ra1,
        output chk_ra2,
        input  pend1,
        input  pend2,
        input  rf_we,
        input  rf_wa,
        input  rf_wd,
        input  fifo_cnt
    );

    modport slave (
`ifdef WBARB_PERF_EN
        output perf_lu_wb,
        output perf_defer,
`endif
        input  pipe_we,
        input  pipe_wa,
        input  pipe_wd,
        input  lu_valid,
        input  lu_wa,
        input  lu_wd,
        output lu_ready,
        input  chk_ra1,
        input  chk_ra2,
        output pend1,
        output pend2,
        output rf_we,
        output rf_wa,
        output rf_wd,
        output fifo_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges WB-stage writes and queued long-latency results
// onto one RF write port. Optional WBARB_PERF_EN adds perf counters.
module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic          live_q [DEPTH];
    logic [AW-1:0] wa_q   [DEPTH];
    logic [DW-1:0] wd_q   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic ready;
    logic empty;
    logic enq;
    logic deq;
    logic pipe_wr;
    logic hit1;
    logic hit2;

    assign ready   = cnt < FULL;
    assign empty   = cnt == '0;
    assign enq     = bus.lu_valid && ready;
    assign pipe_wr = bus.pipe_we && (bus.pipe_wa != '0);
    assign deq     = !pipe_wr && !empty;

    assign bus.lu_ready = ready;
    assign bus.fifo_cnt = cnt;

    // RF port select: pipeline first, then FIFO head, else idle
    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_wa = '0;
        bus.rf_wd = '0;
        if (pipe_wr) begin
            bus.rf_we = 1'b1;
            bus.rf_wa = bus.pipe_wa;
            bus.rf_wd = bus.pipe_wd;
        end else if (!empty) begin
            bus.rf_we = live_q[rd_ptr];
            bus.rf_wa = wa_q[rd_ptr];
            bus.rf_wd = wd_q[rd_ptr];
        end
    end

    // Hazard scan: live queued entries plus the result being accepted now
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && wa_q[i] == bus.chk_ra1) hit1 = 1'b1;
            if (live_q[i] && wa_q[i] == bus.chk_ra2) hit2 = 1'b1;
        end
        if (enq && bus.lu_wa == bus.chk_ra1) hit1 = 1'b1;
        if (enq && bus.lu_wa == bus.chk_ra2) hit2 = 1'b1;
    end

    assign bus.pend1 = (bus.chk_ra1 != '0) && hit1;
    assign bus.pend2 = (bus.chk_ra2 != '0) && hit2;

    // Entry storage: squash older same-register entries, retire head, fill tail
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
                wa_q[i]   <= '0;
                wd_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_wr && wa_q[i] == bus.pipe_wa) live_q[i] <= 1'b0;
            end
            if (deq) live_q[rd_ptr] <= 1'b0;
            if (enq) begin
                live_q[wr_ptr] <= bus.lu_wa != '0;
                wa_q[wr_ptr]   <= bus.lu_wa;
                wd_q[wr_ptr]   <= bus.lu_wd;
            end
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks net occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq) cnt <= cnt + 1'b1;
            else if (deq && !enq) cnt <= cnt - 1'b1;
        end
    end

`ifdef WBARB_PERF_EN
    // Perf: FIFO-sourced RF writes and drains blocked by the pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.perf_lu_wb <= '0;
            bus.perf_defer <= '0;
        end else begin
            if (deq && live_q[rd_ptr]) bus.perf_lu_wb <= bus.perf_lu_wb + 1'b1;
            if (pipe_wr && !empty) bus.perf_defer <= bus.perf_defer + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: queue-based reference model of the arbiter FIFO,
// checked against the DUT every cycle through directed and random stimulus.
module tb_wb_port_arbiter;
    localparam int DEPTH = 4;

    typedef struct {
        logic        live;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ent_t        mq[$];
    logic [31:0] rf_mem [32];
    logic [31:0] m_luwb = '0;
    logic [31:0] m_defer = '0;
    int          nvec = 0;
    int          nerr = 0;

    wb_port_arbiter_if #(.DEPTH(DEPTH), .AW(5), .DW(32)) bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one cycle: drive at negedge, compare just after, model steps at posedge
    task automatic step(input logic r,
                        input logic pwe, input logic [4:0] pwa,
                        input logic [31:0] pwd,
                        input logic lv, input logic [4:0] lwa,
                        input logic [31:0] lwd,
                        input logic [4:0] c1, input logic [4:0] c2);
        logic        pwr, acc, ewe, ep1, ep2;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        ent_t        e;
        @(negedge clk);
        rst          = r;
        bus.pipe_we  = pwe;
        bus.pipe_wa  = pwa;
        bus.pipe_wd  = pwd;
        bus.lu_valid = lv;
        bus.lu_wa    = lwa;
        bus.lu_wd    = lwd;
        bus.chk_ra1  = c1;
        bus.chk_ra2  = c2;
        #1;
        if (r) begin
            mq.delete();
            m_luwb  = '0;
            m_defer = '0;
        end else begin
            pwr = pwe && (pwa != 0);
            acc = lv && (mq.size() < DEPTH);
            ewe = 1'b0;
            ewa = '0;
            ewd = '0;
            if (pwr) begin
                ewe = 1'b1;
                ewa = pwa;
                ewd = pwd;
            end else if (mq.size() > 0) begin
                ewe = mq[0].live;
                ewa = mq[0].wa;
                ewd = mq[0].wd;
            end
            ep1 = acc && (lwa == c1);
            ep2 = acc && (lwa == c2);
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].wa == c1) ep1 = 1'b1;
                if (mq[i].live && mq[i].wa == c2) ep2 = 1'b1;
            end
            ep1 = ep1 && (c1 != 0);
            ep2 = ep2 && (c2 != 0);
            check("lu_ready", bus.lu_ready, mq.size() < DEPTH);
            check("fifo_cnt", bus.fifo_cnt, mq.size());
            check("rf_we", bus.rf_we, ewe);
            check("rf_wa", bus.rf_wa, ewa);
            check("rf_wd", bus.rf_wd, ewd);
            check("pend1", bus.pend1, ep1);
            check("pend2", bus.pend2, ep2);
`ifdef WBARB_PERF_EN
            check("perf_lu_wb", bus.perf_lu_wb, m_luwb);
            check("perf_defer", bus.perf_defer, m_defer);
`endif
            if (bus.rf_we) rf_mem[bus.rf_wa] = bus.rf_wd;
            if (pwr && mq.size() > 0) m_defer++;
            if (!pwr && mq.size() > 0 && mq[0].live) m_luwb++;
            if (pwr) begin
                foreach (mq[i]) if (mq[i].wa == pwa) mq[i].live = 1'b0;
            end else if (mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (acc) begin
                e.live = lwa != 0;
                e.wa   = lwa;
                e.wd   = lwd;
                mq.push_back(e);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
        step(0, 0, 0, 0, 0, 0, 0, c1, c2);
    endtask

    initial begin
        foreach (rf_mem[i]) rf_mem[i] = '0;
        bus.pipe_we  = 0;
        bus.pipe_wa  = 0;
        bus.pipe_wd  = 0;
        bus.lu_valid = 0;
        bus.lu_wa    = 0;
        bus.lu_wd    = 0;
        bus.chk_ra1  = 0;
        bus.chk_ra2  = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);

        // single result, 1-cycle latency, then gone
        step(0, 0, 0, 0, 1, 5, 32'h1234, 5, 0);
        idle(5, 0);
        idle(5, 0);
        check("r5_written", rf_mem[5], 32'h1234);

        // pipe holds the port for 3 cycles, results drain in order after
        step(0, 1, 7, 32'h7, 1, 3, 32'hA, 3, 4);
        step(0, 1, 7, 32'h7, 1, 4, 32'hB, 3, 4);
        step(0, 1, 7, 32'h7, 0, 0, 0, 3, 4);
        idle(3, 4);
        idle(3, 4);
        idle(3, 4);

        // fill with pipe busy, 5th offer refused, one drain frees a slot
        for (int i = 0; i < 5; i++)
            step(0, 1, 1, 32'h11, 1, 5'(10 + i), 32'h100 + i, 5'(10 + i), 14);
        step(0, 0, 0, 0, 1, 20, 32'h200, 14, 20);
        for (int i = 0; i < 6; i++) idle(14, 20);

        // squash: queued r9 overwritten by a younger pipe write
        step(0, 1, 2, 32'h22, 1, 9, 32'h99, 9, 0);
        step(0, 1, 9, 32'h55, 0, 0, 0, 9, 0);
        idle(9, 0);
        idle(9, 0);
        check("r9_kept", rf_mem[9], 32'h55);

        // x0 results occupy a slot; pipe x0 write lets the FIFO drain
        step(0, 1, 2, 32'h22, 1, 0, 32'hDEAD, 0, 6);
        step(0, 1, 2, 32'h22, 1, 6, 32'h66, 0, 6);
        step(0, 1, 0, 32'hBAD, 0, 0, 0, 0, 6);
        step(0, 1, 0, 32'hBAD, 0, 0, 0, 0, 6);
        idle(0, 6);

        // reset with 3 entries queued
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 32'h11, 1, 5'(20 + i), 32'h300 + i, 20, 21);
        step(1, 0, 0, 0, 0, 0, 0, 20, 21);
        idle(20, 21);
        idle(20, 21);

        // random traffic on a small register range
        for (int i = 0; i < 300; i++)
            step(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 $urandom, 1'($urandom_range(0, 9) < 6),
                 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        for (int i = 0; i < 6; i++) idle(1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
